// File: rtl/proc_run_controller_if.sv
// ==========================================================================
// proc_run_controller_if: program stream and instruction-memory write bus.
// Rev 1.0
// ==========================================================================
`default_nettype none

interface proc_run_controller_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_d;

   // master = controller side, slave = host stream source / memory side
   modport master (input s_data, s_valid, output s_ready, mem_we, mem_a, mem_d);
   modport slave  (output s_data, s_valid, input s_ready, mem_we, mem_a, mem_d);
endinterface

`default_nettype wire

// File: rtl/proc_run_controller.sv
// ==========================================================================
// proc_run_controller: loads the core's program, sequences reset/run, reports status.
// Rev 1.0
// ==========================================================================
`default_nettype none

module proc_run_controller #(
   parameter int                ADDR_W     = 9,
   parameter int                DATA_W     = 32,
   parameter int                CYC_W      = 16,
   parameter logic [DATA_W-1:0] HALT_WORD  = {DATA_W{1'b1}},
   parameter int                RST_CYCLES = 2
) (
   input  wire logic               clk,
   input  wire logic               rst,
   proc_run_controller_if.master   bus_if,
   input  wire logic               load_start_i,
   input  wire logic [ADDR_W:0]    load_len_i,
   input  wire logic               run_start_i,
   input  wire logic [CYC_W-1:0]   max_cycles_i,
   input  wire logic               abort_i,
   input  wire logic [DATA_W-1:0]  instr_i,
   output logic                    proc_rst_o,
   output logic                    proc_exec_o,
   output logic                    busy_o,
   output logic                    load_done_o,
   output logic                    done_o,
   output logic                    halted_o,
   output logic                    timeout_o,
   output logic                    err_o,
   output logic [CYC_W-1:0]        cycle_count_o
);
   localparam int              c_rcw      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [c_rcw-1:0] c_rst_last = c_rcw'(RST_CYCLES - 1);
   localparam logic [ADDR_W:0] c_max_len  = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RSTP = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [c_rcw-1:0]    rcnt_q, rcnt_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic                halted_q, halted_d;
   logic                timeout_q, timeout_d;
   logic                err_q, err_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
   logic [DATA_W-1:0]   mem_d_q, mem_d_d;
   logic                load_done_q, load_done_d;

   logic                w_s_ready;
   logic                w_hs;
   logic                w_exec;
   logic                w_len_ok;
   logic [CYC_W-1:0]    w_cyc_inc;

   // exec is combinational so the halt word is never executed and abort bites at once
   assign w_s_ready = (state_q == S_LOAD) && !abort_i;
   assign w_hs      = w_s_ready && bus_if.s_valid;
   assign w_exec    = (state_q == S_RUN) && (instr_i != HALT_WORD) && !abort_i;
   assign w_len_ok  = (load_len_i != '0) && (load_len_i <= c_max_len);
   assign w_cyc_inc = cyc_q + CYC_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      rcnt_d      = rcnt_q;
      cyc_d       = cyc_q;
      halted_d    = halted_q;
      timeout_d   = timeout_q;
      err_d       = err_q;
      mem_we_d    = 1'b0;
      mem_a_d     = mem_a_q;
      mem_d_d     = mem_d_q;
      load_done_d = 1'b0;

      if (abort_i) begin
         state_d   = S_IDLE;
         halted_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (load_start_i) begin
                  if (w_len_ok) begin
                     state_d   = S_LOAD;
                     addr_d    = '0;
                     rem_d     = load_len_i;
                     err_d     = 1'b0;
                     halted_d  = 1'b0;
                     timeout_d = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (run_start_i) begin
                  state_d   = S_RSTP;
                  rcnt_d    = '0;
                  cyc_d     = '0;
                  halted_d  = 1'b0;
                  timeout_d = 1'b0;
               end
            end
            S_LOAD: begin
               if (w_hs) begin
                  mem_we_d = 1'b1;
                  mem_a_d  = addr_q;
                  mem_d_d  = bus_if.s_data;
                  addr_d   = addr_q + ADDR_W'(1);
                  rem_d    = rem_q - (ADDR_W+1)'(1);
                  if (rem_q == (ADDR_W+1)'(1)) begin
                     state_d     = S_IDLE;
                     load_done_d = 1'b1;
                  end
               end
            end
            S_RSTP: begin
               if (rcnt_q == c_rst_last) state_d = S_RUN;
               else                      rcnt_d  = rcnt_q + c_rcw'(1);
            end
            S_RUN: begin
               if (instr_i == HALT_WORD) begin
                  state_d  = S_DONE;
                  halted_d = 1'b1;
               end else begin
                  if (cyc_q != '1) cyc_d = w_cyc_inc;
                  if ((max_cycles_i != '0) && (w_cyc_inc == max_cycles_i)) begin
                     state_d   = S_DONE;
                     timeout_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         rcnt_q      <= '0;
         cyc_q       <= '0;
         halted_q    <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_a_q     <= '0;
         mem_d_q     <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         rcnt_q      <= rcnt_d;
         cyc_q       <= cyc_d;
         halted_q    <= halted_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_a_q     <= mem_a_d;
         mem_d_q     <= mem_d_d;
         load_done_q <= load_done_d;
      end
   end

   assign bus_if.s_ready = w_s_ready;
   assign bus_if.mem_we  = mem_we_q;
   assign bus_if.mem_a   = mem_a_q;
   assign bus_if.mem_d   = mem_d_q;
   assign proc_rst_o     = (state_q == S_RSTP);
   assign proc_exec_o    = w_exec;
   assign busy_o         = (state_q == S_LOAD) || (state_q == S_RSTP) || (state_q == S_RUN);
   assign load_done_o    = load_done_q;
   assign done_o         = (state_q == S_DONE);
   assign halted_o       = halted_q;
   assign timeout_o      = timeout_q;
   assign err_o          = err_q;
   assign cycle_count_o  = cyc_q;
endmodule

`default_nettype wire
